// File: rtl/sseg_to_bin_seq.sv
// Sequential seven-segment to binary converter: captures two operands plus sign and
// operator digits, folds one digit per cycle MSD first, and presents registered results.
module sseg_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7*DIGITS-1:0]   ssegnum_a,
  input  logic [7*DIGITS-1:0]   ssegnum_b,
  input  logic [6:0]            signo_a,
  input  logic [6:0]            signo_b,
  input  logic [6:0]            operador,
  output logic [WIDTH-1:0]      num_a,
  output logic [WIDTH-1:0]      num_b,
  output logic                  sig_a,
  output logic                  sig_b,
  output logic [1:0]            oper,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ovf
);

  // state | meaning
  // IDLE  | waiting for start, results held
  // CONV  | one digit per cycle for both operands, MSD first
  // DONE  | results valid for one cycle, done pulse
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam int AW = WIDTH + 4;
  localparam int SW = 7 * DIGITS;
  localparam int CW = (DIGITS < 2) ? 1 : $clog2(DIGITS + 1);
  localparam logic [AW-1:0] MAXV = {4'b0000, {WIDTH{1'b1}}};

  state_t          state_q, state_d;
  logic [SW-1:0]   seg_a_q, seg_a_d, seg_b_q, seg_b_d;
  logic [6:0]      sgn_a_q, sgn_a_d, sgn_b_q, sgn_b_d, op_q, op_d;
  logic [AW-1:0]   acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] num_a_q, num_a_d, num_b_q, num_b_d;
  logic            sig_a_q, sig_a_d, sig_b_q, sig_b_d;
  logic [1:0]      oper_q, oper_d;
  logic            err_out_q, err_out_d, ovf_out_q, ovf_out_d;

  logic [4:0]      dec_a, dec_b;
  logic [AW:0]     step_a, step_b;
  logic            err_nx, ovf_nx, op_ok;
  logic [1:0]      op_code;

  // {illegal, value}; blank is a legal zero
  function automatic logic [4:0] dec_digit(input logic [6:0] p);
    case (p)
      7'b0000001: dec_digit = 5'd0;
      7'b1001111: dec_digit = 5'd1;
      7'b0010010: dec_digit = 5'd2;
      7'b0000110: dec_digit = 5'd3;
      7'b1001100: dec_digit = 5'd4;
      7'b0100100: dec_digit = 5'd5;
      7'b0100000: dec_digit = 5'd6;
      7'b0001111: dec_digit = 5'd7;
      7'b0000000: dec_digit = 5'd8;
      7'b0000100: dec_digit = 5'd9;
      7'b1111111: dec_digit = 5'd0;
      default:    dec_digit = 5'b10000;
    endcase
  endfunction

  // {saturated, next_acc}; acc never exceeds MAXV so the product fits in AW bits
  function automatic logic [AW:0] acc_step(input logic [AW-1:0] acc, input logic [3:0] d);
    logic [AW-1:0] t;
    t = acc * AW'(10) + AW'(d);
    if (t > MAXV) acc_step = {1'b1, MAXV};
    else          acc_step = {1'b0, t};
  endfunction

  always_comb begin
    state_d   = state_q;
    seg_a_d   = seg_a_q;
    seg_b_d   = seg_b_q;
    sgn_a_d   = sgn_a_q;
    sgn_b_d   = sgn_b_q;
    op_d      = op_q;
    acc_a_d   = acc_a_q;
    acc_b_d   = acc_b_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    num_a_d   = num_a_q;
    num_b_d   = num_b_q;
    sig_a_d   = sig_a_q;
    sig_b_d   = sig_b_q;
    oper_d    = oper_q;
    err_out_d = err_out_q;
    ovf_out_d = ovf_out_q;

    dec_a  = dec_digit(seg_a_q[SW-1 -: 7]);
    dec_b  = dec_digit(seg_b_q[SW-1 -: 7]);
    step_a = acc_step(acc_a_q, dec_a[3:0]);
    step_b = acc_step(acc_b_q, dec_b[3:0]);
    err_nx = err_q | dec_a[4] | dec_b[4];
    ovf_nx = ovf_q | step_a[AW] | step_b[AW];

    op_ok   = 1'b1;
    op_code = 2'd0;
    case (op_q)
      7'b1101100: op_code = 2'd0;
      7'b1111110: op_code = 2'd1;
      7'b1001000: op_code = 2'd2;
      7'b1011011: op_code = 2'd3;
      default:    op_ok   = 1'b0;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CONV;
          seg_a_d = ssegnum_a;
          seg_b_d = ssegnum_b;
          sgn_a_d = signo_a;
          sgn_b_d = signo_b;
          op_d    = operador;
          acc_a_d = '0;
          acc_b_d = '0;
          cnt_d   = CW'(DIGITS - 1);
          err_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      CONV: begin
        seg_a_d = seg_a_q << 7;
        seg_b_d = seg_b_q << 7;
        acc_a_d = step_a[AW-1:0];
        acc_b_d = step_b[AW-1:0];
        err_d   = err_nx;
        ovf_d   = ovf_nx;
        if (cnt_q == '0) begin
          // results land on the edge entering DONE so they are valid with the pulse
          state_d   = DONE;
          num_a_d   = step_a[WIDTH-1:0];
          num_b_d   = step_b[WIDTH-1:0];
          sig_a_d   = (sgn_a_q != 7'b1111111);
          sig_b_d   = (sgn_b_q != 7'b1111111);
          if (op_ok) oper_d = op_code;
          err_out_d = err_nx | ~op_ok;
          ovf_out_d = ovf_nx;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      seg_a_q   <= '0;
      seg_b_q   <= '0;
      sgn_a_q   <= '0;
      sgn_b_q   <= '0;
      op_q      <= '0;
      acc_a_q   <= '0;
      acc_b_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      num_a_q   <= '0;
      num_b_q   <= '0;
      sig_a_q   <= 1'b0;
      sig_b_q   <= 1'b0;
      oper_q    <= '0;
      err_out_q <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seg_a_q   <= seg_a_d;
      seg_b_q   <= seg_b_d;
      sgn_a_q   <= sgn_a_d;
      sgn_b_q   <= sgn_b_d;
      op_q      <= op_d;
      acc_a_q   <= acc_a_d;
      acc_b_q   <= acc_b_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      num_a_q   <= num_a_d;
      num_b_q   <= num_b_d;
      sig_a_q   <= sig_a_d;
      sig_b_q   <= sig_b_d;
      oper_q    <= oper_d;
      err_out_q <= err_out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign num_a = num_a_q;
  assign num_b = num_b_q;
  assign sig_a = sig_a_q;
  assign sig_b = sig_b_q;
  assign oper  = oper_q;
  assign err   = err_out_q;
  assign ovf   = ovf_out_q;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);

endmodule
